axi_wb_buffer: RTL and testbench

- Single-entry write-back buffer between the datapath's cache eviction path and the AXI4 master write channel.
- Captures one dirty 512-bit block plus its address in one cycle, freeing the cache immediately.
- Drains the block as an 8-beat INCR burst of 64-bit beats, advancing one beat per AXI W handshake, and waits for the B response.
- Exposes an address-match flag so the cache can stall a refill of a block that is still draining.

---
 rtl/axi_wb_buffer_pkg.sv | 14 +
 rtl/axi_wb_buffer_en_reg.sv | 21 ++
 rtl/axi_wb_buffer.sv | 108 ++++++++++
 tb/tb_axi_wb_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wb_buffer_pkg.sv
// Shared types and AXI constants for the write-back buffer.
package axi_wb_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_RESP = 2'd2
  } wb_state_t;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam int         BLOCK_OFFSET_BITS = 6;

endpackage

// File: rtl/axi_wb_buffer_en_reg.sv
// Generic enable register, synchronous active-low reset to zero.
// Latency 1 cycle from en; no flow control.
module axi_wb_buffer_en_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!arst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/axi_wb_buffer.sv
// Single-entry eviction buffer draining one block as an 8-beat AXI INCR burst; accept->write_req 1 cycle.
// Backpressure: o_wb_ready only when empty or when the B response retires the held block this cycle.
module axi_wb_buffer
  import axi_wb_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 512,
  parameter int BEAT_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    i_wb_valid,
  output logic                    o_wb_ready,
  input  logic [ADDR_WIDTH-1:0]   i_wb_addr,
  input  logic [BLOCK_WIDTH-1:0]  i_wb_data,
  output logic                    o_write_req,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [BEAT_WIDTH-1:0]   o_write_data,
  output logic [7:0]              o_axi_len,
  output logic [2:0]              o_axi_size,
  output logic [BEAT_WIDTH/8-1:0] o_axi_strb,
  input  logic                    i_axi_handshake,
  input  logic                    i_axi_done,
  input  logic                    i_axi_err,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  output logic                    o_rd_hit,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int BEATS  = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  wb_state_t                             state;
  logic [BEAT_W-1:0]                     beat;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]      data_q;
  logic [ADDR_WIDTH-1:0]                 addr_q;
  logic                                  accept;
  logic                                  unused_low;

  assign o_wb_ready = (state == IDLE) || ((state == WAIT_RESP) && i_axi_done);
  assign accept     = i_wb_valid && o_wb_ready;

  // Block offset bits never take part in the match or the burst address.
  assign unused_low = ^{i_wb_addr[BLOCK_OFFSET_BITS-1:0], i_rd_addr[BLOCK_OFFSET_BITS-1:0]};

  axi_wb_buffer_en_reg #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
    .clk  (clk),
    .arst (arst),
    .en   (accept),
    .d    ({i_wb_addr[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}}),
    .q    (addr_q)
  );

  always_ff @(posedge clk) begin
    if (!arst) begin
      state  <= IDLE;
      beat   <= '0;
      data_q <= '0;
      o_err  <= 1'b0;
    end else begin
      // A B response in WRITE means the slave finished early: treat as an error.
      if (i_axi_done && ((state == WRITE) || ((state == WAIT_RESP) && i_axi_err))) begin
        o_err <= 1'b1;
      end
      if (accept) begin
        state  <= WRITE;
        beat   <= '0;
        data_q <= i_wb_data;
      end else begin
        case (state)
          WRITE: begin
            if (i_axi_done) begin
              state <= IDLE;
              beat  <= '0;
            end else if (i_axi_handshake) begin
              if (beat == LAST_BEAT) begin
                state <= WAIT_RESP;
              end
              beat <= beat + BEAT_ONE;
            end
          end
          WAIT_RESP: begin
            if (i_axi_done) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_write_req  = o_busy;
  assign o_addr       = addr_q;
  assign o_write_data = data_q[beat];
  assign o_rd_hit     = o_busy &&
                        (i_rd_addr[ADDR_WIDTH-1:BLOCK_OFFSET_BITS] == addr_q[ADDR_WIDTH-1:BLOCK_OFFSET_BITS]);
  assign o_axi_len    = 8'(BEATS - 1);
  assign o_axi_size   = 3'($clog2(BEAT_WIDTH / 8));
  assign o_axi_strb   = '1;

endmodule

// File: tb/tb_axi_wb_buffer.sv
// Directed bench for axi_wb_buffer with hand-computed expectations.
module tb_axi_wb_buffer;

  logic         clk = 1'b0;
  logic         arst;
  logic         i_wb_valid;
  logic         o_wb_ready;
  logic [31:0]  i_wb_addr;
  logic [511:0] i_wb_data;
  logic         o_write_req;
  logic [31:0]  o_addr;
  logic [63:0]  o_write_data;
  logic [7:0]   o_axi_len;
  logic [2:0]   o_axi_size;
  logic [7:0]   o_axi_strb;
  logic         i_axi_handshake;
  logic         i_axi_done;
  logic         i_axi_err;
  logic [31:0]  i_rd_addr;
  logic         o_rd_hit;
  logic         o_busy;
  logic         o_err;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  axi_wb_buffer dut (
    .clk             (clk),
    .arst            (arst),
    .i_wb_valid      (i_wb_valid),
    .o_wb_ready      (o_wb_ready),
    .i_wb_addr       (i_wb_addr),
    .i_wb_data       (i_wb_data),
    .o_write_req     (o_write_req),
    .o_addr          (o_addr),
    .o_write_data    (o_write_data),
    .o_axi_len       (o_axi_len),
    .o_axi_size      (o_axi_size),
    .o_axi_strb      (o_axi_strb),
    .i_axi_handshake (i_axi_handshake),
    .i_axi_done      (i_axi_done),
    .i_axi_err       (i_axi_err),
    .i_rd_addr       (i_rd_addr),
    .o_rd_hit        (o_rd_hit),
    .o_busy          (o_busy),
    .o_err           (o_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] blk_seq();
    logic [511:0] b;
    for (int k = 0; k < 8; k++) b[k*64 +: 64] = 64'h11 * 64'(k + 1);
    return b;
  endfunction

  function automatic logic [511:0] blk_tag(input logic [31:0] tag);
    logic [511:0] b;
    for (int k = 0; k < 8; k++) b[k*64 +: 64] = {tag, 32'(k)};
    return b;
  endfunction

  task automatic idle_inputs();
    i_wb_valid      = 1'b0;
    i_wb_addr       = '0;
    i_wb_data       = '0;
    i_axi_handshake = 1'b0;
    i_axi_done      = 1'b0;
    i_axi_err       = 1'b0;
    i_rd_addr       = '0;
  endtask

  task automatic accept(input logic [31:0] a, input logic [511:0] d);
    i_wb_valid = 1'b1;
    i_wb_addr  = a;
    i_wb_data  = d;
    #1;
    chk("accept_ready", 64'(o_wb_ready), 64'd1);
    step();
    i_wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;

    // Reset held with random inputs.
    arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_wb_valid      = 1'($urandom);
      i_wb_addr       = $urandom;
      i_wb_data       = {16{$urandom}};
      i_axi_handshake = 1'($urandom);
      i_axi_done      = 1'($urandom);
      i_axi_err       = 1'($urandom);
      i_rd_addr       = $urandom;
      step();
    end
    chk("rst_write_req", 64'(o_write_req), 64'd0);
    chk("rst_busy",      64'(o_busy),      64'd0);
    chk("rst_rd_hit",    64'(o_rd_hit),    64'd0);
    chk("rst_err",       64'(o_err),       64'd0);
    chk("rst_wb_ready",  64'(o_wb_ready),  64'd1);
    idle_inputs();
    arst = 1'b1;
    step();
    chk("axi_len",  64'(o_axi_len),  64'd7);
    chk("axi_size", 64'(o_axi_size), 64'd3);
    chk("axi_strb", 64'(o_axi_strb), 64'hff);

    // Single drain, handshake every cycle.
    d = blk_seq();
    accept(32'h8000_0048, d);
    chk("sd_addr",     64'(o_addr),      64'h8000_0040);
    chk("sd_req",      64'(o_write_req), 64'd1);
    chk("sd_busy",     64'(o_busy),      64'd1);
    chk("sd_notready", 64'(o_wb_ready),  64'd0);
    for (int k = 0; k < 8; k++) begin
      chk("sd_beat", o_write_data, 64'h11 * 64'(k + 1));
      i_axi_handshake = 1'b1;
      step();
    end
    i_axi_handshake = 1'b0;
    chk("sd_wait_req", 64'(o_write_req), 64'd1);
    step();
    chk("sd_wait_req2", 64'(o_write_req), 64'd1);
    chk("sd_wait_notready", 64'(o_wb_ready), 64'd0);
    i_axi_done = 1'b1;
    #1;
    chk("sd_done_ready", 64'(o_wb_ready), 64'd1);
    step();
    i_axi_done = 1'b0;
    chk("sd_idle_busy", 64'(o_busy),      64'd0);
    chk("sd_idle_req",  64'(o_write_req), 64'd0);
    chk("sd_idle_err",  64'(o_err),       64'd0);

    // Stalled beats: each beat must hold until its handshake.
    d = blk_tag(32'hCAFE_0000);
    accept(32'h1234_5678, d);
    chk("st_addr", 64'(o_addr), 64'h1234_5640);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("st_hold", o_write_data, {32'hCAFE_0000, 32'(k)});
      i_axi_handshake = 1'b1;
      step();
      i_axi_handshake = 1'b0;
    end
    chk("st_wrap",     o_write_data, {32'hCAFE_0000, 32'd0});
    chk("st_wait_req", 64'(o_write_req), 64'd1);
    i_axi_handshake = 1'b1;
    step();
    i_axi_handshake = 1'b0;
    chk("st_hs_ignored", o_write_data, {32'hCAFE_0000, 32'd0});
    chk("st_still_busy", 64'(o_busy),  64'd1);

    // Back-to-back: block offered while the previous one awaits B.
    i_wb_valid = 1'b1;
    i_wb_addr  = 32'h8000_0050;
    i_wb_data  = blk_tag(32'hBEEF_0000);
    #1;
    chk("bb_blocked", 64'(o_wb_ready), 64'd0);
    step();
    chk("bb_blocked2", 64'(o_wb_ready), 64'd0);
    i_axi_done = 1'b1;
    #1;
    chk("bb_ready_on_done", 64'(o_wb_ready), 64'd1);
    step();
    i_axi_done = 1'b0;
    i_wb_valid = 1'b0;
    chk("bb_req_cont", 64'(o_write_req), 64'd1);
    chk("bb_addr",     64'(o_addr),      64'h8000_0040);
    chk("bb_beat0",    o_write_data,     {32'hBEEF_0000, 32'd0});

    // Hazard match during the drain of 0x8000_0040.
    i_rd_addr = 32'h8000_007C;
    #1;
    chk("hz_hit_in", 64'(o_rd_hit), 64'd1);
    i_rd_addr = 32'h8000_0080;
    #1;
    chk("hz_miss_above", 64'(o_rd_hit), 64'd0);
    i_rd_addr = 32'h8000_003F;
    #1;
    chk("hz_miss_below", 64'(o_rd_hit), 64'd0);
    i_rd_addr = 32'h8000_007C;
    for (int k = 0; k < 8; k++) begin
      chk("bb_beat", o_write_data, {32'hBEEF_0000, 32'(k)});
      i_axi_handshake = 1'b1;
      step();
    end
    i_axi_handshake = 1'b0;
    chk("hz_hit_wait", 64'(o_rd_hit), 64'd1);

    // Error response ends the burst and sets a sticky flag.
    i_axi_done = 1'b1;
    i_axi_err  = 1'b1;
    #1;
    chk("hz_hit_done_cycle", 64'(o_rd_hit), 64'd1);
    step();
    i_axi_done = 1'b0;
    i_axi_err  = 1'b0;
    chk("hz_hit_after", 64'(o_rd_hit), 64'd0);
    chk("er_set",       64'(o_err),    64'd1);
    i_axi_done = 1'b1;
    step();
    i_axi_done = 1'b0;
    chk("idle_done_ignored", 64'(o_busy), 64'd0);
    step();
    step();
    chk("er_sticky", 64'(o_err), 64'd1);

    // Reset at beat 4 aborts the burst.
    d = blk_tag(32'h0D0D_0000);
    accept(32'h0000_1000, d);
    for (int k = 0; k < 4; k++) begin
      i_axi_handshake = 1'b1;
      step();
    end
    i_axi_handshake = 1'b0;
    chk("ab_beat4", o_write_data, {32'h0D0D_0000, 32'd4});
    arst = 1'b0;
    step();
    arst = 1'b1;
    chk("ab_busy", 64'(o_busy),      64'd0);
    chk("ab_req",  64'(o_write_req), 64'd0);
    chk("ab_err",  64'(o_err),       64'd0);
    chk("ab_addr", 64'(o_addr),      64'd0);
    d = blk_tag(32'hE0E0_0000);
    accept(32'h2000_0000, d);
    chk("ab_restart_beat0", o_write_data, {32'hE0E0_0000, 32'd0});
    chk("ab_restart_busy",  64'(o_busy),  64'd1);

    // Early B in WRITE completes the transfer as a protocol error.
    for (int k = 0; k < 2; k++) begin
      i_axi_handshake = 1'b1;
      step();
    end
    i_axi_handshake = 1'b0;
    chk("early_beat2", o_write_data, {32'hE0E0_0000, 32'd2});
    i_axi_done = 1'b1;
    step();
    i_axi_done = 1'b0;
    chk("early_idle", 64'(o_busy), 64'd0);
    chk("early_err",  64'(o_err),  64'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
